fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Control and data-buffer stage that sits directly upstream of the CORDIC butterfly and consumes its results.
- Buffers one N-point complex frame and runs an in-place radix-2 decimation-in-time FFT by issuing every butterfly operand pair plus its twiddle angle to one butterfly instance.
- Writes each butterfly result back into the buffer, then streams the finished spectrum out in natural order.
- Provides valid/ready streaming on both the input side and the output side.

Parameters:
- N, 8: FFT size; power of two, 4..64.
- LOGN, 3: log2(N).
- FULL_TURN, 32'sd23592960: zangle encoding of 360 degrees (degrees in Q16.16), matching the CORDIC angle format.
- SCALE, 1: 1 = arithmetic right-shift both butterfly operands by 1 before issue (divide by N overall); 0 = no scaling.

Ports:
- clock  in  1  system clock; all flops are rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts an input sample.
- in_re  in  16  signed real part of the input sample.
- in_im  in  16  signed imaginary part of the input sample.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the output bin.
- out_re  out  16  signed real part of the output bin.
- out_im  out  16  signed imaginary part of the output bin.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in ISSUE, WAIT or WRITE.
- bf_x1, bf_y1, bf_x2, bf_y2  out  16 each  butterfly operands: top (x1,y1) and bottom (x2,y2), signed.
- bf_zangle  out  32  signed twiddle angle applied to the bottom operand.
- bf_xout1, bf_yout1, bf_xout2, bf_yout2  in  16 each  butterfly results.
- bf_done  in  1  butterfly results valid (AND of both CORDIC dones).

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted and after it releases:
  - state = LOAD; all counters = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; busy = 0.
  - All bf_* outputs = 0; out_re and out_im = 0.
  - Buffer contents are don't-care.
- Reset asserted mid-frame aborts the frame; no partial output is ever produced.
- Storage: N x 32-bit register file (re, im).
- LOAD:
  - An input sample is accepted on each cycle with in_valid && in_ready.
  - Sample n is written at address bitrev(n) over LOGN bits.
  - After the N-th accept: in_ready drops on the next cycle; go to ISSUE with stage s = 0 and butterfly index b = 0.
- Butterfly addressing (half = 2^s):
  - j = b mod half; top = (b / half) * 2 * half + j; bot = top + half.
  - k = j * (N / (2 * half)).
  - bf_zangle = -(k * FULL_TURN / N), computed exactly and truncated toward zero.
- ISSUE (1 cycle): drive the operands from buffer[top] and buffer[bot], shifted per SCALE; go to WAIT.
- Operand hold: all bf_* outputs are registered and stay stable from ISSUE until WRITE completes.
- WAIT:
  - bf_done is ignored in the first WAIT cycle, so a stale done from the previous butterfly is never sampled.
  - From the second WAIT cycle on, bf_done = 1 captures the four results and moves to WRITE.
  - There is no timeout.
- WRITE (1 cycle):
  - buffer[top] = (bf_xout1, bf_yout1); buffer[bot] = (bf_xout2, bf_yout2).
  - Advance b. If b wraps past N/2-1, set b = 0 and advance s. If s wraps past LOGN-1, go to UNLOAD; otherwise go to ISSUE.
- Arithmetic: no saturation; results wrap two's-complement.
- UNLOAD:
  - out_valid = 1 with out = buffer[m], m = 0..N-1 in natural order; out_last = 1 when m = N-1.
  - m advances only on out_valid && out_ready. Holding out_ready low freezes out_* unchanged.
  - After the last handshake: out_valid = 0 on the next cycle; state returns to LOAD with in_ready = 1.
- Input/output overlap: none. in_ready = 0 everywhere except LOAD, and in_valid is ignored outside LOAD.
- Cycle budget per frame, with D = bf_done latency (D >= 2 cycles):
  - Compute: (N/2) * LOGN * (D + 2) cycles.
  - Plus N load handshakes and N unload handshakes.

Test Plan:
- Use a bench butterfly model that asserts bf_done 5 cycles after any operand change; run N = 8, SCALE = 0.
- Impulse (x[0] = 1000+0j, others 0) -> all 8 bins = 1000+0j (+/-2 LSB CORDIC tolerance); out_last only on bin 7; busy high for exactly 12 * 7 = 84 cycles.
- DC (all samples 100+0j) -> bin0 = 800+0j, bins 1..7 = 0 (+/-2 LSB).
- SCALE = 1, x[1] = 800+0j -> bin k = 100 * e^(-j2*pi*k/8); check bin2 = 0-100j and bin4 = -100+0j (+/-2 LSB).
- Angle check, stage 2 of N = 8: butterflies b = 0..3 carry bf_zangle = 0, -2949120, -5898240, -8847360.
- Backpressure: toggle out_ready 1,0,0,1,... -> bin sequence is unchanged with no drop or duplicate; in_valid pulses during UNLOAD are ignored (in_ready = 0).
- Reset asserted in the 3rd WAIT of stage 1 -> out_valid and busy go low immediately and in_ready = 1; a fresh impulse frame then produces the correct result.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// Frame buffer and sequencer for an in-place radix-2 DIT FFT built around one external
// butterfly: bit-reversed load, per-butterfly operand/twiddle issue, write-back, natural-order unload.
module fft_stage_sequencer #(
   parameter int                 N         = 8,
   parameter int                 LOGN      = 3,
   parameter logic signed [31:0] FULL_TURN = 32'sd23592960,
   parameter int                 SCALE     = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in_re,
   input  logic signed [15:0] in_im,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_re,
   output logic signed [15:0] out_im,
   output logic               out_last,
   output logic               busy,
   output logic signed [15:0] bf_x1,
   output logic signed [15:0] bf_y1,
   output logic signed [15:0] bf_x2,
   output logic signed [15:0] bf_y2,
   output logic signed [31:0] bf_zangle,
   input  logic signed [15:0] bf_xout1,
   input  logic signed [15:0] bf_yout1,
   input  logic signed [15:0] bf_xout2,
   input  logic signed [15:0] bf_yout2,
   input  logic               bf_done
);
   // state  | meaning
   // LOAD   | accept N samples, stored at bit-reversed addresses
   // ISSUE  | register operands and twiddle of butterfly (stage, bfly)
   // WAIT   | hold operands; bf_done honoured from the second cycle on
   // WRITE  | store captured results back at top/bot, advance bfly/stage
   // UNLOAD | stream bins 0..N-1 in natural order
   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_UNLOAD = 3'd4
   } state_t;

   localparam int AW = LOGN;
   localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
   localparam int BW = (LOGN > 1) ? LOGN - 1 : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
   localparam logic [BW-1:0] LAST_BF  = BW'(N / 2 - 1);
   localparam logic [SW-1:0] LAST_ST  = SW'(LOGN - 1);

   state_t state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [BW-1:0] bfly_q, bfly_d;
   logic wait_arm_q, wait_arm_d;

   logic signed [15:0] mem_re_q [N];
   logic signed [15:0] mem_re_d [N];
   logic signed [15:0] mem_im_q [N];
   logic signed [15:0] mem_im_d [N];

   logic signed [15:0] res_x1_q, res_x1_d, res_y1_q, res_y1_d;
   logic signed [15:0] res_x2_q, res_x2_d, res_y2_q, res_y2_d;
   logic signed [15:0] bf_x1_q, bf_x1_d, bf_y1_q, bf_y1_d;
   logic signed [15:0] bf_x2_q, bf_x2_d, bf_y2_q, bf_y2_d;
   logic signed [31:0] bf_zangle_q, bf_zangle_d;

   logic [AW-1:0] half_m, j_a, top_a, bot_a, k_a;
   logic signed [63:0] ang_prod, ang_quot;
   logic signed [31:0] zangle_c;
   logic in_fire, out_fire, done_seen, last_bf, last_st;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   function automatic logic signed [15:0] scale_op(input logic signed [15:0] v);
      return (SCALE != 0) ? (v >>> 1) : v;
   endfunction

   assign in_fire   = in_valid && (state_q == ST_LOAD);
   assign out_fire  = out_ready && (state_q == ST_UNLOAD);
   assign done_seen = (state_q == ST_WAIT) && wait_arm_q && bf_done;
   assign last_bf   = (bfly_q == LAST_BF);
   assign last_st   = (stage_q == LAST_ST);

   // top = (b / half) * 2 * half + j, bot = top + half, k = j * N / (2 * half)
   always_comb begin
      half_m = AW'(1) << stage_q;
      j_a    = AW'(bfly_q) & (half_m - 1'b1);
      top_a  = (((AW'(bfly_q) >> stage_q) << 1) << stage_q) | j_a;
      bot_a  = top_a | half_m;
      k_a    = j_a << (LAST_ST - stage_q);
   end

   // Signed divide truncates toward zero, matching the exact-then-truncate angle rule.
   always_comb begin
      ang_prod = $signed({{(64-AW){1'b0}}, k_a}) * 64'(FULL_TURN);
      ang_quot = ang_prod / 64'(N);
      zangle_c = 32'(-ang_quot);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_LOAD;
         idx_q       <= '0;
         stage_q     <= '0;
         bfly_q      <= '0;
         wait_arm_q  <= 1'b0;
         res_x1_q    <= '0;
         res_y1_q    <= '0;
         res_x2_q    <= '0;
         res_y2_q    <= '0;
         bf_x1_q     <= '0;
         bf_y1_q     <= '0;
         bf_x2_q     <= '0;
         bf_y2_q     <= '0;
         bf_zangle_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         bfly_q      <= bfly_d;
         wait_arm_q  <= wait_arm_d;
         res_x1_q    <= res_x1_d;
         res_y1_q    <= res_y1_d;
         res_x2_q    <= res_x2_d;
         res_y2_q    <= res_y2_d;
         bf_x1_q     <= bf_x1_d;
         bf_y1_q     <= bf_y1_d;
         bf_x2_q     <= bf_x2_d;
         bf_y2_q     <= bf_y2_d;
         bf_zangle_q <= bf_zangle_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_re_q <= mem_re_d;
      mem_im_q <= mem_im_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD:   if (in_fire && idx_q == LAST_IDX) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT:   if (done_seen) state_d = ST_WRITE;
         ST_WRITE:  state_d = (last_bf && last_st) ? ST_UNLOAD : ST_ISSUE;
         ST_UNLOAD: if (out_fire && idx_q == LAST_IDX) state_d = ST_LOAD;
         default:   state_d = ST_LOAD;
      endcase
   end

   // idx and bfly are exactly log2 wide, so increments wrap to 0 at frame/stage end.
   always_comb begin
      idx_d      = idx_q;
      stage_d    = stage_q;
      bfly_d     = bfly_q;
      wait_arm_d = wait_arm_q;
      if (in_fire || out_fire) idx_d = idx_q + 1'b1;
      if (state_q == ST_ISSUE) wait_arm_d = 1'b0;
      else if (state_q == ST_WAIT) wait_arm_d = 1'b1;
      if (state_q == ST_WRITE) begin
         bfly_d = bfly_q + 1'b1;
         if (last_bf) stage_d = last_st ? '0 : stage_q + 1'b1;
      end
   end

   always_comb begin
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      if (in_fire) begin
         mem_re_d[bitrev(idx_q)] = in_re;
         mem_im_d[bitrev(idx_q)] = in_im;
      end else if (state_q == ST_WRITE) begin
         mem_re_d[top_a] = res_x1_q;
         mem_im_d[top_a] = res_y1_q;
         mem_re_d[bot_a] = res_x2_q;
         mem_im_d[bot_a] = res_y2_q;
      end
   end

   always_comb begin
      bf_x1_d     = bf_x1_q;
      bf_y1_d     = bf_y1_q;
      bf_x2_d     = bf_x2_q;
      bf_y2_d     = bf_y2_q;
      bf_zangle_d = bf_zangle_q;
      res_x1_d    = res_x1_q;
      res_y1_d    = res_y1_q;
      res_x2_d    = res_x2_q;
      res_y2_d    = res_y2_q;
      if (state_q == ST_ISSUE) begin
         bf_x1_d     = scale_op(mem_re_q[top_a]);
         bf_y1_d     = scale_op(mem_im_q[top_a]);
         bf_x2_d     = scale_op(mem_re_q[bot_a]);
         bf_y2_d     = scale_op(mem_im_q[bot_a]);
         bf_zangle_d = zangle_c;
      end
      if (done_seen) begin
         res_x1_d = bf_xout1;
         res_y1_d = bf_yout1;
         res_x2_d = bf_xout2;
         res_y2_d = bf_yout2;
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
      out_valid = (state_q == ST_UNLOAD);
      out_last  = (state_q == ST_UNLOAD) && (idx_q == LAST_IDX);
      out_re    = (state_q == ST_UNLOAD) ? mem_re_q[idx_q] : '0;
      out_im    = (state_q == ST_UNLOAD) ? mem_im_q[idx_q] : '0;
   end

   assign bf_x1     = bf_x1_q;
   assign bf_y1     = bf_y1_q;
   assign bf_x2     = bf_x2_q;
   assign bf_y2     = bf_y2_q;
   assign bf_zangle = bf_zangle_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: instance 0 runs SCALE=0, instance 1 runs SCALE=1,
// each paired with an ideal rounded butterfly whose done rises 5 cycles after ISSUE.
module tb_fft_stage_sequencer;
   logic clock = 1'b0;
   logic reset;
   logic in_valid [2], in_ready [2], out_valid [2], out_ready [2], out_last [2], busy [2];
   logic bf_done [2];
   logic signed [15:0] in_re [2], in_im [2], out_re [2], out_im [2];
   logic signed [15:0] bf_x1 [2], bf_y1 [2], bf_x2 [2], bf_y2 [2];
   logic signed [15:0] bf_xout1 [2], bf_yout1 [2], bf_xout2 [2], bf_yout2 [2];
   logic signed [31:0] bf_zangle [2];
   logic [63:0] bf_res [2];
   int t_ph [2] = '{0, 0};

   int errors = 0;
   int checks = 0;
   logic signed [15:0] frame_re [8], frame_im [8];
   logic signed [15:0] got_re [8], got_im [8];
   logic got_last [8];
   int exp_re [8], exp_im [8];
   int busy_tot = 0;
   logic [7:0] zidx = 8'd0;
   logic signed [31:0] zlog [256];

   always #5 clock = ~clock;

   fft_stage_sequencer #(.N(8), .LOGN(3), .FULL_TURN(32'sd23592960), .SCALE(0)) u_dut0 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_re(in_re[0]), .in_im(in_im[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_re(out_re[0]), .out_im(out_im[0]),
      .out_last(out_last[0]), .busy(busy[0]),
      .bf_x1(bf_x1[0]), .bf_y1(bf_y1[0]), .bf_x2(bf_x2[0]), .bf_y2(bf_y2[0]),
      .bf_zangle(bf_zangle[0]),
      .bf_xout1(bf_xout1[0]), .bf_yout1(bf_yout1[0]), .bf_xout2(bf_xout2[0]), .bf_yout2(bf_yout2[0]),
      .bf_done(bf_done[0]));

   fft_stage_sequencer #(.N(8), .LOGN(3), .FULL_TURN(32'sd23592960), .SCALE(1)) u_dut1 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_re(in_re[1]), .in_im(in_im[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_re(out_re[1]), .out_im(out_im[1]),
      .out_last(out_last[1]), .busy(busy[1]),
      .bf_x1(bf_x1[1]), .bf_y1(bf_y1[1]), .bf_x2(bf_x2[1]), .bf_y2(bf_y2[1]),
      .bf_zangle(bf_zangle[1]),
      .bf_xout1(bf_xout1[1]), .bf_yout1(bf_yout1[1]), .bf_xout2(bf_xout2[1]), .bf_yout2(bf_yout2[1]),
      .bf_done(bf_done[1]));

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
   endfunction

   // Ideal butterfly: out1 = a + W*b, out2 = a - W*b, W = e^(j*zangle), zangle in Q16.16 degrees.
   function automatic logic [63:0] bfly_model(input logic signed [15:0] x1, y1, x2, y2,
                                              input logic signed [31:0] za);
      real th, c, s, rr, ri;
      int o1r, o1i, o2r, o2i;
      th  = (real'(za) / 65536.0) * (3.14159265358979 / 180.0);
      c   = $cos(th);
      s   = $sin(th);
      rr  = real'(x2) * c - real'(y2) * s;
      ri  = real'(x2) * s + real'(y2) * c;
      o1r = rnd(real'(x1) + rr);
      o1i = rnd(real'(y1) + ri);
      o2r = rnd(real'(x1) - rr);
      o2i = rnd(real'(y1) - ri);
      return {o1r[15:0], o1i[15:0], o2r[15:0], o2i[15:0]};
   endfunction

   // t_ph: 0 = ISSUE, 1..5 = WAIT, 6 = WRITE; done also stays high through WRITE/ISSUE/first WAIT.
   always @(posedge clock or posedge reset) begin
      for (int u = 0; u < 2; u++) begin
         if (reset || !busy[u] || t_ph[u] == 6) t_ph[u] <= 0;
         else t_ph[u] <= t_ph[u] + 1;
      end
   end

   always_comb begin
      for (int u = 0; u < 2; u++) begin
         bf_done[u]  = busy[u] && (t_ph[u] >= 5 || t_ph[u] <= 1);
         bf_res[u]   = bfly_model(bf_x1[u], bf_y1[u], bf_x2[u], bf_y2[u], bf_zangle[u]);
         bf_xout1[u] = bf_res[u][63:48];
         bf_yout1[u] = bf_res[u][47:32];
         bf_xout2[u] = bf_res[u][31:16];
         bf_yout2[u] = bf_res[u][15:0];
      end
   end

   always @(negedge clock) begin
      if (busy[0]) busy_tot <= busy_tot + 1;
      if (busy[0] && t_ph[0] == 1) begin
         zlog[zidx] <= bf_zangle[0];
         zidx <= zidx + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int exp);
      int d;
      bit ok;
      checks++;
      d  = obs - exp;
      ok = (d <= 2) && (d >= -2);
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (+/-2)", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input int u);
      int n, cyc;
      n = 0;
      cyc = 0;
      while (n < 8 && cyc < 200) begin
         in_valid[u] = 1'b1;
         in_re[u] = frame_re[n];
         in_im[u] = frame_im[n];
         if (in_ready[u]) n++;
         @(negedge clock);
         cyc++;
      end
      in_valid[u] = 1'b0;
      chk("load_count", n, 8);
      chk("load_ready_drop", in_ready[u], 0);
   endtask

   task automatic unload_frame(input int u, input bit bp, input bit poke);
      int n, cyc;
      bit hold;
      logic signed [15:0] hold_re, hold_im;
      n = 0;
      cyc = 0;
      hold = 1'b0;
      hold_re = '0;
      hold_im = '0;
      while (n < 8 && cyc < 3000) begin
         out_ready[u] = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (poke) in_valid[u] = (cyc % 2 == 1);
         if (hold) begin
            chk("hold_re", out_re[u], hold_re);
            chk("hold_im", out_im[u], hold_im);
            hold = 1'b0;
         end
         if (out_valid[u]) begin
            if (poke) chk("unload_in_ready", in_ready[u], 0);
            if (out_ready[u]) begin
               got_re[n] = out_re[u];
               got_im[n] = out_im[u];
               got_last[n] = out_last[u];
               n++;
            end else begin
               hold = 1'b1;
               hold_re = out_re[u];
               hold_im = out_im[u];
            end
         end
         @(negedge clock);
         cyc++;
      end
      in_valid[u] = 1'b0;
      out_ready[u] = 1'b0;
      chk("unload_count", n, 8);
      chk("unload_valid_drop", out_valid[u], 0);
      chk("unload_in_ready_back", in_ready[u], 1);
   endtask

   task automatic check_bins(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk_near($sformatf("%s_re%0d", tag, i), int'(got_re[i]), exp_re[i]);
         chk_near($sformatf("%s_im%0d", tag, i), int'(got_im[i]), exp_im[i]);
         chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == 7) ? 1 : 0);
      end
   endtask

   task automatic set_impulse();
      for (int i = 0; i < 8; i++) begin
         frame_re[i] = '0;
         frame_im[i] = '0;
         exp_re[i] = 1000;
         exp_im[i] = 0;
      end
      frame_re[0] = 16'sd1000;
   endtask

   initial begin
      int b0, cyc;
      logic [7:0] z0;
      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0;
         out_ready[u] = 1'b0;
         in_re[u] = '0;
         in_im[u] = '0;
      end
      repeat (3) @(negedge clock);
      chk("rst_in_ready", in_ready[0], 1);
      chk("rst_out_valid", out_valid[0], 0);
      chk("rst_out_last", out_last[0], 0);
      chk("rst_busy", busy[0], 0);
      chk("rst_bf_x1", bf_x1[0], 0);
      chk("rst_bf_zangle", bf_zangle[0], 0);
      chk("rst_out_re", out_re[0], 0);
      chk("rst_in_ready_s1", in_ready[1], 1);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_in_ready", in_ready[0], 1);
      chk("post_rst_busy", busy[0], 0);

      // Impulse: flat spectrum, 12 butterflies x 7 busy cycles, twiddle sequence per stage
      set_impulse();
      b0 = busy_tot;
      z0 = zidx;
      load_frame(0);
      unload_frame(0, 1'b0, 1'b0);
      check_bins("imp");
      chk("imp_busy_cycles", busy_tot - b0, 84);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ang_s0_b%0d", i), zlog[8'(int'(z0) + i)], 0);
         chk($sformatf("ang_s1_b%0d", i), zlog[8'(int'(z0) + 4 + i)], (i % 2) * -5898240);
         chk($sformatf("ang_s2_b%0d", i), zlog[8'(int'(z0) + 8 + i)], i * -2949120);
      end

      // DC with 1,0,0,1 backpressure and in_valid pokes during unload
      for (int i = 0; i < 8; i++) begin
         frame_re[i] = 16'sd100;
         frame_im[i] = '0;
         exp_re[i] = (i == 0) ? 800 : 0;
         exp_im[i] = 0;
      end
      load_frame(0);
      unload_frame(0, 1'b1, 1'b1);
      check_bins("dc_bp");

      // Impulse again: any sample accepted during the previous unload would corrupt this frame
      set_impulse();
      load_frame(0);
      unload_frame(0, 1'b0, 1'b0);
      check_bins("imp2");

      // SCALE=1 instance, x[1] = 800 -> 100 * e^(-j*pi*k/4)
      for (int i = 0; i < 8; i++) begin
         frame_re[i] = '0;
         frame_im[i] = '0;
      end
      frame_re[1] = 16'sd800;
      exp_re = '{100, 71, 0, -71, -100, -71, 0, 71};
      exp_im = '{0, -71, -100, -71, 0, 71, 100, 71};
      load_frame(1);
      unload_frame(1, 1'b0, 1'b0);
      check_bins("scl");

      // Reset during the 3rd WAIT of stage 1 (butterfly index 4)
      set_impulse();
      z0 = zidx;
      load_frame(0);
      cyc = 0;
      while (!(busy[0] && t_ph[0] == 3 && 8'(zidx - z0) == 8'd5) && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
      chk("rst_mid_reached", (cyc < 2000) ? 1 : 0, 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_out_valid", out_valid[0], 0);
      chk("rst_mid_busy", busy[0], 0);
      chk("rst_mid_in_ready", in_ready[0], 1);
      chk("rst_mid_bf_x1", bf_x1[0], 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      load_frame(0);
      unload_frame(0, 1'b0, 1'b0);
      check_bins("imp3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
